// File: rtl/score_board.sv
// score_board: multi-lane score accumulator with combo multiplier and per-level high-score table.
// Revision: 1.0
`default_nettype none

module score_board #(
  parameter int NUM_LANES      = 8,
  parameter int SCORE_W        = 16,
  parameter int COMBO_W        = 8,
  parameter int POINTS_PER_HIT = 10,
  parameter int MULT_STEP      = 10,
  parameter int MAX_MULT       = 4,
  parameter int LEVEL_W        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [LEVEL_W-1:0]   level,
  input  logic [NUM_LANES-1:0] noteAction,
  input  logic [NUM_LANES-1:0] noteSuccessState,
  output logic [SCORE_W-1:0]   score,
  output logic [COMBO_W-1:0]   combo,
  output logic [3:0]           multiplier,
  output logic [SCORE_W-1:0]   best_score,
  output logic                 new_record
);

  localparam int DEPTH  = 1 << LEVEL_W;
  localparam int HITS_W = $clog2(NUM_LANES + 1);
  localparam int SUM_W  = SCORE_W + 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [COMBO_W-1:0]   combo_q, combo_d;
  logic [3:0]           multiplier_q, multiplier_d;
  logic                 new_record_q, new_record_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [SCORE_W-1:0]   table_q [DEPTH];
  logic [SCORE_W-1:0]   table_d [DEPTH];

  logic [HITS_W-1:0]    hits, misses;
  logic [SUM_W-1:0]     add, score_sum;
  logic [COMBO_W:0]     combo_sum;
  logic [COMBO_W-1:0]   tier;

  always_comb begin
    hits   = '0;
    misses = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (noteAction[i]) begin
        if (noteSuccessState[i]) hits   = hits + HITS_W'(1);
        else                     misses = misses + HITS_W'(1);
      end
    end
  end

  // Points use the multiplier earned before this cycle's hits land.
  assign add       = SUM_W'(hits) * SUM_W'(POINTS_PER_HIT) * SUM_W'(multiplier_q);
  assign score_sum = SUM_W'(score_q) + add;
  assign combo_sum = {1'b0, combo_q} + (COMBO_W + 1)'(hits);

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    combo_d      = combo_q;
    new_record_d = new_record_q;
    level_d      = level_q;
    table_d      = table_q;

    case (state_q)
      IDLE: begin
        if (mode) begin
          state_d      = PLAY;
          score_d      = '0;
          combo_d      = '0;
          new_record_d = 1'b0;
          level_d      = level;
        end
      end
      PLAY: begin
        if (!mode) state_d = COMMIT;
        score_d = (score_sum[SUM_W-1:SCORE_W] != '0) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        if (misses != '0)        combo_d = '0;
        else if (combo_sum[COMBO_W]) combo_d = {COMBO_W{1'b1}};
        else                     combo_d = combo_sum[COMBO_W-1:0];
      end
      COMMIT: begin
        state_d = IDLE;
        if (score_q > table_q[level_q]) begin
          table_d[level_q] = score_q;
          new_record_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    tier = combo_d / COMBO_W'(MULT_STEP);
    if (tier >= COMBO_W'(MAX_MULT - 1)) multiplier_d = 4'(MAX_MULT);
    else                                multiplier_d = 4'(tier) + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      score_q      <= '0;
      combo_q      <= '0;
      multiplier_q <= 4'd1;
      new_record_q <= 1'b0;
      level_q      <= '0;
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      combo_q      <= combo_d;
      multiplier_q <= multiplier_d;
      new_record_q <= new_record_d;
      level_q      <= level_d;
      table_q      <= table_d;
    end
  end

  // In IDLE the display follows the live level selector; during a game it tracks the latched one.
  assign best_score = (state_q == IDLE) ? table_q[level] : table_q[level_q];
  assign score      = score_q;
  assign combo      = combo_q;
  assign multiplier = multiplier_q;
  assign new_record = new_record_q;

endmodule

`default_nettype wire

// File: tb/tb_score_board.sv
// tb_score_board: directed self-checking bench for score_board.
// Revision: 1.0
`default_nettype none

module tb_score_board;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  level;
  logic [7:0]  note_action;
  logic [7:0]  note_success;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [3:0]  multiplier;
  logic [15:0] best_score;
  logic        new_record;

  int checks = 0;
  int errors = 0;

  score_board dut (
    .clk              (clk),
    .rst              (rst),
    .mode             (mode),
    .level            (level),
    .noteAction       (note_action),
    .noteSuccessState (note_success),
    .score            (score),
    .combo            (combo),
    .multiplier       (multiplier),
    .best_score       (best_score),
    .new_record       (new_record)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic notes(input int n, input logic [7:0] a, input logic [7:0] s);
    note_action  = a;
    note_success = s;
    repeat (n) tick();
    note_action  = '0;
    note_success = '0;
  endtask

  task automatic end_game();
    mode = 1'b0;
    tick();  // last PLAY edge -> COMMIT
    tick();  // COMMIT edge -> IDLE
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; level = 2'd0; note_action = '0; note_success = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_score", score, 0);
    check("rst_combo", combo, 0);
    check("rst_mult", multiplier, 1);
    check("rst_newrec", new_record, 0);
    check("rst_best", best_score, 0);

    // Game 1, level 2: single hit then multiplier step
    level = 2'd2; mode = 1'b1;
    note_action = 8'hFF; note_success = 8'hFF;  // ignored on the entry edge
    tick();
    note_action = '0; note_success = '0;
    check("entry_score", score, 0);
    notes(1, 8'h01, 8'h01);
    check("hit1_score", score, 10);
    check("hit1_combo", combo, 1);
    check("hit1_mult", multiplier, 1);
    notes(9, 8'h01, 8'h01);
    check("hit10_score", score, 100);
    check("hit10_combo", combo, 10);
    check("hit10_mult", multiplier, 2);
    notes(1, 8'h01, 8'h01);
    check("hit11_score", score, 120);
    check("hit11_combo", combo, 11);
    mode = 1'b0;
    tick();
    check("commit_best_old", best_score, 0);
    check("commit_newrec_old", new_record, 0);
    tick();
    check("g1_best", best_score, 120);
    check("g1_newrec", new_record, 1);
    check("g1_score_hold", score, 120);
    check("g1_combo_hold", combo, 11);

    // Game 2, level 2: lower score is not a record
    mode = 1'b1;
    tick();
    check("g2_entry_score", score, 0);
    check("g2_entry_newrec", new_record, 0);
    check("g2_entry_best", best_score, 120);
    notes(5, 8'h01, 8'h01);
    check("g2_score", score, 50);
    end_game();
    check("g2_best", best_score, 120);
    check("g2_newrec", new_record, 0);
    level = 2'd1;
    #1;
    check("idle_level1_best", best_score, 0);

    // Events in IDLE are ignored
    notes(2, 8'hFF, 8'hFF);
    check("idle_ignore_score", score, 50);

    // Game 3, level 1: mixed simultaneous resolutions
    mode = 1'b1;
    tick();
    notes(5, 8'h01, 8'h01);
    check("g3_c5_score", score, 50);
    check("g3_c5_combo", combo, 5);
    notes(1, 8'h0F, 8'h07);
    check("mixed_score", score, 80);
    check("mixed_combo", combo, 0);
    check("mixed_mult", multiplier, 1);
    notes(12, 8'h01, 8'h01);
    check("g3_c12_score", score, 220);
    check("g3_c12_combo", combo, 12);
    notes(1, 8'h03, 8'h03);
    check("dual_score", score, 260);
    check("dual_combo", combo, 14);
    level = 2'd3;  // must not move the commit target
    #1;
    check("play_best_latched", best_score, 0);
    end_game();
    check("g3_best_lvl3", best_score, 0);
    level = 2'd1;
    #1;
    check("g3_best_lvl1", best_score, 260);
    check("g3_newrec", new_record, 1);

    // Game 4, level 0: saturation
    level = 2'd0; mode = 1'b1;
    tick();
    notes(2100, 8'hFF, 8'hFF);
    check("sat_score", score, 65535);
    check("sat_combo", combo, 255);
    check("sat_mult", multiplier, 4);
    end_game();
    check("sat_best", best_score, 65535);
    check("sat_newrec", new_record, 1);

    // Game 5, level 3: reset mid-game discards everything
    level = 2'd3; mode = 1'b1;
    tick();
    notes(8, 8'h01, 8'h01);
    check("g5_score", score, 80);
    rst = 1'b1; mode = 1'b0;
    tick();
    rst = 1'b0;
    check("mrst_score", score, 0);
    check("mrst_combo", combo, 0);
    check("mrst_newrec", new_record, 0);
    for (int l = 0; l < 4; l++) begin
      level = 2'(l);
      #1;
      check($sformatf("mrst_best_l%0d", l), best_score, 0);
    end
    notes(3, 8'h01, 8'h01);
    check("mrst_idle_score", score, 0);
    tick();
    check("mrst_no_commit", new_record, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/score_board.md
Name: score_board

Overview:
- Parametrised successor to the single-level score keeper and high-score register pair.
- Accumulates score across NUM_LANES note lanes, including simultaneous resolutions in one cycle.
- Adds a combo counter with tiered multiplier and a per-level high-score table with a new-record flag.
- Feeds binary score and best score to the BCD/seven-segment path; consumes note events from the VGA note engine.

Parameters:
- NUM_LANES, 8: number of note lanes (width of event buses).
- SCORE_W, 16: score/high-score width, saturating.
- COMBO_W, 8: combo counter width, saturating.
- POINTS_PER_HIT, 10: base points per successful note.
- MULT_STEP, 10: consecutive hits per multiplier increment.
- MAX_MULT, 4: multiplier ceiling (≤15).
- LEVEL_W, 2: level index width; table depth 2**LEVEL_W.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  1 = game running, 0 = idle/menu.
- level  in  LEVEL_W  selected level.
- noteAction  in  NUM_LANES  1-cycle pulse per lane when that lane's note resolves.
- noteSuccessState  in  NUM_LANES  per lane: 1 = hit, 0 = miss; valid where noteAction=1.
- score  out  SCORE_W  current game score.
- combo  out  COMBO_W  consecutive-hit count.
- multiplier  out  4  current multiplier, 1..MAX_MULT.
- best_score  out  SCORE_W  high score of the displayed level.
- new_record  out  1  last finished game set a new high score.

Behaviour:
- Reset (rst=1 at a clk edge):
  - score=0, combo=0, multiplier=1, new_record=0.
  - All table entries = 0; state=IDLE; latched level = 0.
  - Reset mid-game discards the game; no commit.
- FSM states: IDLE, PLAY, COMMIT.
  - IDLE -> PLAY when mode=1. On the entry edge: score=0, combo=0, new_record=0, level latched.
  - PLAY -> COMMIT when mode=0.
  - COMMIT -> IDLE unconditionally after 1 cycle.
  - mode re-asserted during COMMIT is honoured from IDLE on the next cycle.
- Events are processed only in PLAY. noteAction is ignored in IDLE and COMMIT, including the PLAY entry cycle.
- Per-cycle update in PLAY; inputs at edge t produce outputs after edge t+1 (1-cycle latency):
  - hits = popcount(noteAction & noteSuccessState).
  - misses = popcount(noteAction & ~noteSuccessState).
  - add = hits × POINTS_PER_HIT × multiplier, using the multiplier in effect before this update. Compute at SCORE_W+8 bits.
  - score = min(score + add, 2**SCORE_W−1).
  - If misses>0: combo=0, even when hits>0 in the same cycle. Else combo = min(combo + hits, 2**COMBO_W−1).
- multiplier = min(1 + combo/MULT_STEP, MAX_MULT), a registered function of combo. It updates in the same cycle combo does.
- COMMIT cycle: if score > table[latched level], write score into the table and set new_record=1. Otherwise leave the table and new_record unchanged.
  - Equal score is not a record.
- new_record holds until the next PLAY entry or reset.
- score and combo hold their final values through COMMIT and IDLE for display.
- best_score:
  - IDLE: table[level], combinational from the live level input through a registered table.
  - PLAY/COMMIT: table[latched level].
  - After a commit write, shows the new value from the cycle following COMMIT.
- Changes to level during PLAY do not affect the commit target.

Test Plan:
- Single hit: mode=1 then noteAction=8'h01, noteSuccessState=8'h01 -> next cycle score=10, combo=1, multiplier=1.
- Multiplier step: ten single-lane hits on consecutive cycles -> score=100, combo=10, multiplier=2; 11th hit -> score=120, combo=11.
- Simultaneous mixed: at combo=5, noteAction=8'h0F, noteSuccessState=8'h07 -> score +30, combo=0, multiplier=1. At combo=12, noteAction=8'h03 with both hits -> score +40, combo=14.
- Saturation: hold noteAction=noteSuccessState=8'hFF for 2100 cycles -> combo saturates at 255, multiplier=4, score clamps at 65535 and holds.
- High score: level=2, game to score=120, mode=0 -> best_score=120, new_record=1. Second game on level 2 ending at 50 -> best_score stays 120, new_record=0. Switching level to 1 in IDLE -> best_score=0.
- Reset mid-game: score=80 on level 3, assert rst for 1 cycle -> score=0, combo=0, best_score=0 for all levels, state IDLE, no commit.
